// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: digit-load and display-pin signals between the value producer, the scan controller and the board
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [3:0]                bcd_out;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (output load, digits_in, input bcd_out, an, frame_done);
    modport slave  (input load, digits_in, output bcd_out, an, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-segment scanner with frame-synchronous double-buffered digits
// Optional feature: define SEG_LZB_EN to blank leading zeros during DRIVE.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DRIVE_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic             clk,
    input logic             rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int MAXC = DRIVE_CYCLES > BLANK_CYCLES ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         active_q, active_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [3:0]            bcd_q, bcd_d;
    logic                  fd_q, fd_d;
    logic                  blank_end, drive_end, frame_end;
    logic [3:0]            digit;
    logic                  lz_blank;

    // Next scan position and buffer state; a load on the frame-end edge lands in shadow for the next frame
    always_comb begin
        blank_end = state_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1);
        drive_end = state_q == DRIVE && cnt_q == CW'(DRIVE_CYCLES - 1);
        frame_end = drive_end && idx_q == IW'(NUM_DIGITS - 1);
        state_d   = blank_end ? DRIVE : drive_end ? BLANK : state_q;
        cnt_d     = (blank_end || drive_end) ? '0 : cnt_q + 1'b1;
        idx_d     = frame_end ? '0 : drive_end ? idx_q + 1'b1 : idx_q;
        active_d  = (frame_end && pending_q) ? shadow_q : active_q;
        shadow_d  = bus.load ? bus.digits_in : shadow_q;
        pending_d = bus.load | (pending_q & ~frame_end);
        fd_d      = frame_end;
        digit     = active_d[{idx_d, 2'b00} +: 4];
    end

`ifdef SEG_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        lz_blank = idx_d != '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (k >= int'(idx_d) && active_d[4*k +: 4] != 4'h0) lz_blank = 1'b0;
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Output pins follow the next state so they change on the same edge as state/idx
    always_comb begin
        an_d  = state_d == DRIVE ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        bcd_d = (state_d == DRIVE && !lz_blank) ? digit : 4'hF;
    end

    // Scan FSM, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            bcd_q     <= 4'hF;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.frame_done = fd_q;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It shares one BCD-to-7-segment decoder across NUM_DIGITS digit positions: it drives the decoder's 4-bit BCD input and the active-low digit anode enables. A blanking gap between digits prevents ghosting. Digit data is double-buffered and committed only at frame boundaries, so the display never tears. The block sits between the value-producing logic (counters, BCD converters) and the board's segment/anode pins.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digit positions scanned (2..8)
- DRIVE_CYCLES, 50000, clk cycles each digit is lit (>=1)
- BLANK_CYCLES, 500, clk cycles all anodes are off before each digit (>=1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; capture digits_in into the shadow buffer
- digits_in  in  4*NUM_DIGITS  packed BCD; digit k = bits [4k+3:4k]; digit 0 is rightmost
- bcd_out  out  4  to the shared decoder; 4'hF when blanked, which the decoder renders as all segments off
- an  out  NUM_DIGITS  anode enables, active-low; an[k]=0 lights digit k
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- State machine with two states: BLANK and DRIVE. A cycle counter cnt and a digit index idx (0..NUM_DIGITS-1) run alongside it.
- BLANK:
  - Lasts BLANK_CYCLES cycles.
  - an = all ones; bcd_out = 4'hF.
  - Then go to DRIVE with cnt=0.
- DRIVE:
  - Lasts DRIVE_CYCLES cycles.
  - an = all ones except an[idx]=0; bcd_out = active digit idx.
  - Then go to BLANK and set idx = idx+1.
  - idx wraps from NUM_DIGITS-1 to 0; this wrap is the frame end.
- Scan order is 0,1,…,NUM_DIGITS-1, repeating.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DRIVE_CYCLES).
- Buffering:
  - load writes digits_in into shadow and sets pending=1.
  - At a frame end with pending=1, active takes the shadow value and pending clears.
  - When load coincides with a frame end:
    - active takes the shadow value held before that edge.
    - The new data goes to shadow and pending stays 1, so it commits at the next frame end.
  - Repeated loads within a frame: the last one wins.
- Non-decimal digits (A–E) pass through unmodified; the decoder blanks them. Digit value F is indistinguishable from blank.
- Reset values (apply on the cycle after the rst edge; reset overrides everything, including mid-DRIVE):
  - Registers: state=BLANK, cnt=0, idx=0, shadow=0, active=0, pending=0.
  - Outputs: an=all ones, bcd_out=4'hF, frame_done=0.

## Timing
- an, bcd_out and frame_done are registered. They change on the same edge as state/idx, with no combinational path from inputs.
- Cycle numbering below starts at 0 = the first cycle after rst deasserts.
  - Cycles 0..BLANK_CYCLES-1 are BLANK for idx 0.
  - DRIVE for idx 0 follows immediately.
- frame_done is high for exactly the first BLANK cycle of each new frame (never after reset). active already holds the committed value in that cycle.
- Load-to-display latency: from the next frame end plus BLANK_CYCLES up to one frame period plus BLANK_CYCLES.
- A load that misses a frame end by one cycle is committed at the following frame end.

## Configuration
- SEG_LZB_EN (leading-zero blanking):
  - Defined: during DRIVE, any digit above the most-significant nonzero digit of active outputs bcd_out=4'hF with its anode still asserted. Digit 0 is never blanked, so active=0 shows a single "0".
  - Not defined: every digit shows its active value.
  - Scan timing and the anode pattern are identical either way.

## Test plan
Bench parameters: NUM_DIGITS=4, BLANK_CYCLES=2, DRIVE_CYCLES=4; frame = 24 cycles.
- Reset/scan: release rst.
  - Cycles 0–1: an=1111, bcd_out=F. Cycles 2–5: an=1110, bcd_out=0. Cycles 8–11: an=1101.
  - frame_done high only at cycles 24, 48.
- Load commit: load=1 with digits_in=16'h1234 at cycle 5.
  - Cycles 2–23 keep showing 0s; frame_done at cycle 24.
  - Cycles 26–29: bcd_out=4, an=1110. Cycles 32–35: bcd_out=3. Cycles 44–47: bcd_out=1, an=0111.
- Coincident load: load 16'h1111 at cycle 10, then 16'h5678 at cycle 23 (the last cycle before the frame end).
  - Frame 2 shows 1111; frame 3 shows 5678; pending clears at cycle 48.
- Reset mid-operation: assert rst at cycle 28 (mid-DRIVE, active=1234).
  - Next cycle: an=1111, bcd_out=F, active=0.
  - Scan restarts at idx 0 with BLANK.
- Invalid digit: load 16'h00A0. Digit 1 drives bcd_out=A with an=1101.
- With SEG_LZB_EN defined:
  - Load 16'h0070: digits 3 and 2 drive F with an asserted; digit 1 drives 7; digit 0 drives 0.
  - Load 16'h0000: only digit 0 drives 0. Without the macro, all four digits drive 0.
